// File: rtl/lsu_pkg.sv
// Shared constants and state encoding for the sequential load/store unit.
package lsu_pkg;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-memory bus signals of the load/store unit.
interface lsu_if #(
    parameter int XLEN = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        opcode;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [XLEN-1:0]   imm;

    logic              mem_req;
    logic              mem_we;
    logic [XLEN-1:0]   mem_addr;
    logic [XLEN/8-1:0] mem_be;
    logic [XLEN-1:0]   mem_wdata;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;

    logic              resp_valid;
    logic              has_result;
    logic [XLEN-1:0]   result;
    logic              error;

    modport slave (
        input  req_valid, opcode, funct3, rs1, rs2, imm, mem_ack, mem_rdata,
        output req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               resp_valid, has_result, result, error
    );

    modport master (
        output req_valid, opcode, funct3, rs1, rs2, imm, mem_ack, mem_rdata,
        input  req_ready, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
               resp_valid, has_result, result, error
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane helper: strobes, lane-shifted store data, extended load data,
// misalignment and funct3 legality for one access size/offset.
module lsu_align
    import lsu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [2:0]       funct3,
    input  logic             is_store,
    input  logic [OFF_W-1:0] offset,
    input  logic [XLEN-1:0]  wdata,
    input  logic [XLEN-1:0]  rdata,
    output logic [NB-1:0]    be,
    output logic [XLEN-1:0]  wdata_lane,
    output logic [XLEN-1:0]  rdata_ext,
    output logic             misalign,
    output logic             illegal
);
    logic [NB-1:0]     size_mask;
    logic [OFF_W-1:0]  align_mask;
    logic [XLEN-1:0]   shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] word_s;

    assign shifted = rdata >> {offset, 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = shifted[15:0];
    assign word_s  = shifted[31:0];

    always_comb begin
        size_mask  = '0;
        align_mask = '0;
        case (funct3[1:0])
            2'd0: begin size_mask = NB'(1);  align_mask = '0;        end
            2'd1: begin size_mask = NB'(3);  align_mask = OFF_W'(1); end
            2'd2: begin size_mask = NB'(15); align_mask = OFF_W'(3); end
            default: begin size_mask = '1;   align_mask = '1;        end
        endcase
    end

    assign be         = size_mask << offset;
    assign wdata_lane = wdata << {offset, 3'b000};
    assign misalign   = (offset & align_mask) != '0;

    // Unsigned variants exist only for loads; doubles need a 64-bit datapath.
    always_comb begin
        illegal = 1'b1;
        case (funct3)
            F3_B, F3_H, F3_W:    illegal = 1'b0;
            F3_D:                illegal = (XLEN != 64);
            F3_BU, F3_HU, F3_WU: illegal = is_store;
            default:             illegal = 1'b1;
        endcase
    end

    always_comb begin
        rdata_ext = shifted;
        case (funct3[1:0])
            2'd0:    rdata_ext = funct3[2] ? XLEN'(shifted[7:0])  : XLEN'(byte_s);
            2'd1:    rdata_ext = funct3[2] ? XLEN'(shifted[15:0]) : XLEN'(half_s);
            2'd2:    rdata_ext = funct3[2] ? XLEN'(shifted[31:0]) : XLEN'(word_s);
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_seq.sv
// Multi-cycle load/store unit with a single-outstanding ack-handshake bus.
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module lsu_seq
    import lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic  clk,
    input logic  rst,
    lsu_if.slave bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e        state_q, state_d;
    logic [XLEN-1:0]   addr_sum;
    logic              is_load, is_store, req_err, accept, timeout_hit;
    logic              req_ready_c, mem_req_c, resp_valid_c;

    logic [2:0]        funct3_q;
    logic [OFF_W-1:0]  offset_q;
    logic              load_q;

    logic [2:0]        al_funct3;
    logic [OFF_W-1:0]  al_offset;
    logic [NB-1:0]     al_be;
    logic [XLEN-1:0]   al_wdata, al_rdata_ext;
    logic              al_misalign, al_illegal;

    logic              mem_we_q;
    logic [XLEN-1:0]   mem_addr_q, mem_wdata_q, result_q;
    logic [NB-1:0]     mem_be_q;
    logic              error_q, has_result_q;

    assign addr_sum = bus.rs1 + bus.imm;
    assign is_load  = (bus.opcode == OP_LOAD);
    assign is_store = (bus.opcode == OP_STORE);
    assign accept   = (state_q == ST_IDLE) && bus.req_valid;

    // One aligner serves both paths: request fields while idle, latched fields once on the bus.
    assign al_funct3 = (state_q == ST_IDLE) ? bus.funct3 : funct3_q;
    assign al_offset = (state_q == ST_IDLE) ? addr_sum[OFF_W-1:0] : offset_q;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3     (al_funct3),
        .is_store   (is_store),
        .offset     (al_offset),
        .wdata      (bus.rs2),
        .rdata      (bus.mem_rdata),
        .be         (al_be),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata_ext),
        .misalign   (al_misalign),
        .illegal    (al_illegal)
    );

    assign req_err = !(is_load || is_store) || al_illegal || al_misalign;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || state_q != ST_BUS) begin
            tmo_cnt_q <= '0;
        end else if (!bus.mem_ack) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end

    // Fires on the TIMEOUT_CYCLES-th bus cycle without ack; an ack in that cycle still wins.
    assign timeout_hit = (state_q == ST_BUS) && !bus.mem_ack &&
                         (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_ready_c  = 1'b0;
        mem_req_c    = 1'b0;
        resp_valid_c = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready_c = 1'b1;
                if (bus.req_valid) state_d = req_err ? ST_RESP : ST_BUS;
            end
            ST_BUS: begin
                mem_req_c = 1'b1;
                if (bus.mem_ack || timeout_hit) state_d = ST_RESP;
            end
            ST_RESP: begin
                resp_valid_c = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus fields load only on a legal accept; response fields load only when entering RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            funct3_q     <= '0;
            offset_q     <= '0;
            load_q       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            result_q     <= '0;
            error_q      <= 1'b0;
            has_result_q <= 1'b0;
        end else begin
            if (accept && !req_err) begin
                funct3_q    <= bus.funct3;
                offset_q    <= addr_sum[OFF_W-1:0];
                load_q      <= is_load;
                mem_we_q    <= is_store;
                mem_addr_q  <= addr_sum & ~XLEN'(NB - 1);
                mem_be_q    <= al_be;
                mem_wdata_q <= al_wdata;
            end
            if (accept && req_err) begin
                result_q     <= '0;
                error_q      <= 1'b1;
                has_result_q <= 1'b0;
            end
            if (state_q == ST_BUS && bus.mem_ack) begin
                result_q     <= load_q ? al_rdata_ext : '0;
                error_q      <= 1'b0;
                has_result_q <= load_q;
            end else if (timeout_hit) begin
                result_q     <= '0;
                error_q      <= 1'b1;
                has_result_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.mem_req    = mem_req_c;
    assign bus.resp_valid = resp_valid_c;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.result     = result_q;
    assign bus.error      = error_q;
    assign bus.has_result = has_result_q;

endmodule

// File: tb/tb_lsu_seq.sv
// Scoreboard bench for lsu_seq: bus responder, response queue, per-scenario tasks.
module tb_lsu_seq;
    import lsu_pkg::*;

    localparam int XLEN = 32;
    localparam int TMO  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if #(.XLEN(XLEN)) bus ();

    lsu_seq #(.XLEN(XLEN), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        err;
        logic        hr;
        logic [31:0] res;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ack_after = number of bus cycles before ack (0 = never ack)
    task automatic do_op(input string name, input logic [4:0] op, input logic [2:0] f3,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input int ack_after, input logic [31:0] rdata,
                         input logic exp_bus, input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic exp_err, input logic exp_hr,
                         input logic [31:0] exp_res, input int exp_lat);
        exp_t e, got;
        int   nbus;
        logic seen_req, done;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready got %b want 1", name, bus.req_ready);
        end
        bus.req_valid = 1'b1;
        bus.opcode    = op;
        bus.funct3    = f3;
        bus.rs1       = rs1;
        bus.rs2       = rs2;
        bus.imm       = imm;
        e.err = exp_err;
        e.hr  = exp_hr;
        e.res = exp_res;
        sb_q.push_back(e);
        tick();
        bus.req_valid = 1'b0;
        nbus = 0;
        seen_req = 1'b0;
        done = 1'b0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            if (bus.resp_valid === 1'b1) begin
                done = 1'b1;
                got = sb_q.pop_front();
                checks++;
                if (cyc != exp_lat) begin
                    errors++;
                    $display("FAIL %s latency got %0d want %0d", name, cyc, exp_lat);
                end
                checks++;
                if ({bus.error, bus.has_result, bus.result} !== {got.err, got.hr, got.res}) begin
                    errors++;
                    $display("FAIL %s resp got err=%b hr=%b res=%h want err=%b hr=%b res=%h",
                             name, bus.error, bus.has_result, bus.result, got.err, got.hr, got.res);
                end
                checks++;
                if (bus.mem_req !== 1'b0 || seen_req !== exp_bus) begin
                    errors++;
                    $display("FAIL %s bus_use got mem_req=%b seen=%b want mem_req=0 seen=%b",
                             name, bus.mem_req, seen_req, exp_bus);
                end
            end else begin
                if (bus.mem_req === 1'b1) begin
                    seen_req = 1'b1;
                    nbus++;
                    checks++;
                    if ({bus.mem_addr, bus.mem_be, bus.mem_we} !== {exp_addr, exp_be, op == OP_STORE}) begin
                        errors++;
                        $display("FAIL %s bus got addr=%h be=%b we=%b want addr=%h be=%b we=%b",
                                 name, bus.mem_addr, bus.mem_be, bus.mem_we,
                                 exp_addr, exp_be, op == OP_STORE);
                    end
                    if (op == OP_STORE) begin
                        checks++;
                        if (bus.mem_wdata !== exp_wdata) begin
                            errors++;
                            $display("FAIL %s wdata got %h want %h", name, bus.mem_wdata, exp_wdata);
                        end
                    end
                    if (nbus == ack_after) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = rdata;
                    end
                end
                tick();
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = 32'h5A5A_5A5A;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s resp_valid never seen within 40 cycles", name);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end else begin
            tick();
            checks++;
            if ({bus.resp_valid, bus.req_ready, bus.result} !== {1'b0, 1'b1, got.res}) begin
                errors++;
                $display("FAIL %s after_resp got rv=%b rdy=%b res=%h want rv=0 rdy=1 res=%h",
                         name, bus.resp_valid, bus.req_ready, bus.result, got.res);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset req_ready got %b want 1", bus.req_ready);
        end
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
             bus.resp_valid, bus.has_result, bus.result, bus.error} !== '0) begin
            errors++;
            $display("FAIL reset outputs got req=%b we=%b addr=%h be=%b wd=%h rv=%b hr=%b res=%h err=%b want all 0",
                     bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                     bus.resp_valid, bus.has_result, bus.result, bus.error);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store();
        do_op("sw_basic", OP_STORE, F3_W, 32'h100, 32'hDEAD_BEEF, 32'h4, 3, 32'h0,
              1'b1, 32'h104, 4'b1111, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 4);
        for (int k = 0; k < 4; k++) begin
            do_op($sformatf("sb_off%0d", k), OP_STORE, F3_B, 32'h300, 32'h1122_33A5, k, 1, 32'h0,
                  1'b1, 32'h300, 4'(1 << k), 32'h1122_33A5 << (8 * k), 1'b0, 1'b0, 32'h0, 2);
        end
        do_op("sh_upper", OP_STORE, F3_H, 32'h300, 32'h0000_BEEF, 32'h2, 2, 32'h0,
              1'b1, 32'h300, 4'b1100, 32'hBEEF_0000, 1'b0, 1'b0, 32'h0, 3);
    endtask

    task automatic test_load();
        do_op("lb_sign", OP_LOAD, F3_B, 32'h200, 32'h0, 32'h3, 1, 32'h80FF_FFFF,
              1'b1, 32'h200, 4'b1000, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80, 2);
        do_op("lbu_zero", OP_LOAD, F3_BU, 32'h200, 32'h0, 32'h3, 2, 32'h80FF_FFFF,
              1'b1, 32'h200, 4'b1000, 32'h0, 1'b0, 1'b1, 32'h0000_0080, 3);
        do_op("lh_sign", OP_LOAD, F3_H, 32'h100, 32'h0, 32'h2, 1, 32'h8001_1234,
              1'b1, 32'h100, 4'b1100, 32'h0, 1'b0, 1'b1, 32'hFFFF_8001, 2);
        do_op("lhu_zero", OP_LOAD, F3_HU, 32'h100, 32'h0, 32'h2, 1, 32'h8001_1234,
              1'b1, 32'h100, 4'b1100, 32'h0, 1'b0, 1'b1, 32'h0000_8001, 2);
        do_op("lw_wrap", OP_LOAD, F3_W, 32'hFFFF_FFFC, 32'h0, 32'h8, 1, 32'h1234_5678,
              1'b1, 32'h4, 4'b1111, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 2);
        do_op("lw_negimm", OP_LOAD, F3_W, 32'h10, 32'h0, 32'hFFFF_FFF4, 1, 32'h8765_4321,
              1'b1, 32'h4, 4'b1111, 32'h0, 1'b0, 1'b1, 32'h8765_4321, 2);
    endtask

    task automatic test_errors();
        do_op("sh_misalign", OP_STORE, F3_H, 32'h100, 32'h1234, 32'h1, 1, 32'h0,
              1'b0, 32'h0, 4'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1);
        do_op("lw_misalign", OP_LOAD, F3_W, 32'h100, 32'h0, 32'h2, 1, 32'h0,
              1'b0, 32'h0, 4'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1);
        do_op("bad_opcode", 5'b00100, F3_W, 32'h100, 32'h0, 32'h0, 1, 32'h0,
              1'b0, 32'h0, 4'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1);
        do_op("load_f3_111", OP_LOAD, 3'b111, 32'h100, 32'h0, 32'h0, 1, 32'h0,
              1'b0, 32'h0, 4'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1);
        do_op("store_f3_bu", OP_STORE, F3_BU, 32'h100, 32'h0, 32'h0, 1, 32'h0,
              1'b0, 32'h0, 4'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1);
        do_op("sd_on_rv32", OP_STORE, F3_D, 32'h100, 32'h0, 32'h0, 1, 32'h0,
              1'b0, 32'h0, 4'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1);
        do_op("lw_after_err", OP_LOAD, F3_W, 32'h100, 32'h0, 32'h0, 1, 32'hCAFE_0001,
              1'b1, 32'h100, 4'b1111, 32'h0, 1'b0, 1'b1, 32'hCAFE_0001, 2);
    endtask

    task automatic test_ack_outside_bus();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.mem_ack = 1'b0;
        checks++;
        if ({bus.req_ready, bus.mem_req, bus.resp_valid} !== 3'b100) begin
            errors++;
            $display("FAIL stray_ack got rdy=%b req=%b rv=%b want 1 0 0",
                     bus.req_ready, bus.mem_req, bus.resp_valid);
        end
        tick();
        checks++;
        if (bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_ack_late resp_valid got %b want 0", bus.resp_valid);
        end
    endtask

    task automatic test_reset_abort();
        logic saw_rv;
        bus.req_valid = 1'b1;
        bus.opcode    = OP_LOAD;
        bus.funct3    = F3_W;
        bus.rs1       = 32'h400;
        bus.imm       = 32'h0;
        tick();
        bus.req_valid = 1'b0;
        checks++;
        if (bus.mem_req !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre mem_req got %b want 1", bus.mem_req);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.mem_req, bus.req_ready, bus.resp_valid} !== 3'b010) begin
            errors++;
            $display("FAIL abort got req=%b rdy=%b rv=%b want 0 1 0",
                     bus.mem_req, bus.req_ready, bus.resp_valid);
        end
        rst = 1'b0;
        saw_rv = 1'b0;
        repeat (3) begin
            tick();
            if (bus.resp_valid === 1'b1) saw_rv = 1'b1;
        end
        checks++;
        if (saw_rv !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_resp resp_valid seen got 1 want 0");
        end
        do_op("lw_after_abort", OP_LOAD, F3_W, 32'h400, 32'h0, 32'h0, 2, 32'h0BAD_F00D,
              1'b1, 32'h400, 4'b1111, 32'h0, 1'b0, 1'b1, 32'h0BAD_F00D, 3);
    endtask

    task automatic test_timeout();
`ifdef LSU_TIMEOUT_EN
        do_op("lw_timeout", OP_LOAD, F3_W, 32'h500, 32'h0, 32'h0, 0, 32'h0,
              1'b1, 32'h500, 4'b1111, 32'h0, 1'b1, 1'b0, 32'h0, TMO + 1);
        do_op("lw_ack_at_tmo", OP_LOAD, F3_W, 32'h500, 32'h0, 32'h0, TMO, 32'hCAFE_F00D,
              1'b1, 32'h500, 4'b1111, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, TMO + 1);
`else
        do_op("lw_long_wait", OP_LOAD, F3_W, 32'h500, 32'h0, 32'h0, 10, 32'hCAFE_F00D,
              1'b1, 32'h500, 4'b1111, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 11);
`endif
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.opcode    = '0;
        bus.funct3    = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.imm       = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_store();
        test_load();
        test_errors();
        test_ack_outside_bus();
        test_reset_abort();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
